// File: rtl/turn_scheduler.sv
// Turn sequencer for the game FSM: arbitrates two player move sources, issues one
// move per turn, waits for the game acknowledge, and enforces turn timeout and limit.
module turn_scheduler #(
    parameter int unsigned TURN_CYCLES = 50,
    parameter int unsigned MAX_TURNS   = 9,
    parameter int unsigned CNT_W       = 6
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             p0_req,
    input  logic [2:0]       p0_move,
    input  logic             p1_req,
    input  logic [2:0]       p1_move,
    input  logic             game_ack,
    input  logic             game_over,
    output logic             move_valid,
    output logic [2:0]       move_out,
    output logic             player,
    output logic             timeout,
    output logic [CNT_W-1:0] turn_cnt,
    output logic             busy,
    output logic             done
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT_MOVE,
        S_ISSUE,
        S_WAIT_ACK,
        S_SWITCH,
        S_DONE
    } state_t;

    localparam logic [CNT_W-1:0] TIMER_RELOAD = CNT_W'(TURN_CYCLES - 1);
    localparam logic [CNT_W-1:0] TURN_LIMIT   = CNT_W'(MAX_TURNS);

    state_t           r_state, w_state_nxt;
    logic [CNT_W-1:0] r_timer, w_timer_nxt;
    logic [CNT_W-1:0] r_turn_cnt, w_turn_cnt_nxt;
    logic [CNT_W-1:0] w_turn_inc;
    logic             r_player, w_player_nxt;
    logic [2:0]       r_move_out, w_move_out_nxt;
    logic             r_move_valid, w_move_valid_nxt;
    logic             r_timeout, w_timeout_nxt;
    logic             r_busy, w_busy_nxt;
    logic             r_done, w_done_nxt;
    logic             w_cur_req;
    logic [2:0]       w_cur_move;

    // State and registered outputs
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state      <= S_IDLE;
            r_timer      <= '0;
            r_turn_cnt   <= '0;
            r_player     <= 1'b0;
            r_move_out   <= 3'b000;
            r_move_valid <= 1'b0;
            r_timeout    <= 1'b0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_timer      <= w_timer_nxt;
            r_turn_cnt   <= w_turn_cnt_nxt;
            r_player     <= w_player_nxt;
            r_move_out   <= w_move_out_nxt;
            r_move_valid <= w_move_valid_nxt;
            r_timeout    <= w_timeout_nxt;
            r_busy       <= w_busy_nxt;
            r_done       <= w_done_nxt;
        end
    end

    // Next-state and next-output logic
    always_comb begin
        w_state_nxt      = r_state;
        w_timer_nxt      = r_timer;
        w_turn_cnt_nxt   = r_turn_cnt;
        w_player_nxt     = r_player;
        w_move_out_nxt   = r_move_out;
        w_timeout_nxt    = 1'b0;
        w_move_valid_nxt = 1'b0;
        w_busy_nxt       = 1'b0;
        w_done_nxt       = 1'b0;
        w_turn_inc       = r_turn_cnt + CNT_W'(1);
        w_cur_req        = r_player ? p1_req  : p0_req;
        w_cur_move       = r_player ? p1_move : p0_move;

        case (r_state)
            S_IDLE, S_DONE: begin
                if (start) begin
                    w_state_nxt    = S_WAIT_MOVE;
                    w_player_nxt   = 1'b0;
                    w_turn_cnt_nxt = '0;
                    w_timer_nxt    = TIMER_RELOAD;
                end
            end
            S_WAIT_MOVE: begin
                // A request on the last timer cycle still wins over the timeout
                if (w_cur_req) begin
                    w_move_out_nxt = w_cur_move;
                    w_state_nxt    = S_ISSUE;
                end else if (r_timer == '0) begin
                    w_timeout_nxt = 1'b1;
                    w_state_nxt   = S_SWITCH;
                end else begin
                    w_timer_nxt = r_timer - CNT_W'(1);
                end
            end
            S_ISSUE: begin
                w_state_nxt = S_WAIT_ACK;
            end
            S_WAIT_ACK: begin
                if (game_ack) begin
                    if (game_over) begin
                        w_turn_cnt_nxt = w_turn_inc;
                        w_state_nxt    = S_DONE;
                    end else begin
                        w_state_nxt = S_SWITCH;
                    end
                end
            end
            S_SWITCH: begin
                w_turn_cnt_nxt = w_turn_inc;
                w_player_nxt   = ~r_player;
                w_timer_nxt    = TIMER_RELOAD;
                w_state_nxt    = (w_turn_inc == TURN_LIMIT) ? S_DONE : S_WAIT_MOVE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase

        w_move_valid_nxt = (w_state_nxt == S_ISSUE);
        w_busy_nxt       = (w_state_nxt != S_IDLE) && (w_state_nxt != S_DONE);
        w_done_nxt       = (w_state_nxt == S_DONE);
    end

    assign move_valid = r_move_valid;
    assign move_out   = r_move_out;
    assign player     = r_player;
    assign timeout    = r_timeout;
    assign turn_cnt   = r_turn_cnt;
    assign busy       = r_busy;
    assign done       = r_done;

endmodule

// File: tb/tb_turn_scheduler.sv
// Turn-level bench for turn_scheduler: directed game scenarios plus random games,
// each turn checked against a player/turn-count model kept in the bench.
module tb_turn_scheduler;

    localparam int unsigned TC = 50;
    localparam int unsigned MT = 9;
    localparam int unsigned CW = 6;

    logic          clk;
    logic          rst;
    logic          start;
    logic          p0_req;
    logic [2:0]    p0_move;
    logic          p1_req;
    logic [2:0]    p1_move;
    logic          game_ack;
    logic          game_over;
    logic          move_valid;
    logic [2:0]    move_out;
    logic          player;
    logic          timeout;
    logic [CW-1:0] turn_cnt;
    logic          busy;
    logic          done;

    int   checks   = 0;
    int   failures = 0;
    logic exp_player;
    int   exp_cnt;
    bit   fin;

    turn_scheduler #(
        .TURN_CYCLES(TC),
        .MAX_TURNS  (MT),
        .CNT_W      (CW)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .p0_req    (p0_req),
        .p0_move   (p0_move),
        .p1_req    (p1_req),
        .p1_move   (p1_move),
        .game_ack  (game_ack),
        .game_over (game_over),
        .move_valid(move_valid),
        .move_out  (move_out),
        .player    (player),
        .timeout   (timeout),
        .turn_cnt  (turn_cnt),
        .busy      (busy),
        .done      (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Current player gets cur_*, the other player gets oth_*
    task automatic drive(input logic cr, input logic [2:0] cm, input logic orq, input logic [2:0] om);
        if (exp_player == 1'b0) begin
            p0_req = cr;  p0_move = cm;  p1_req = orq; p1_move = om;
        end else begin
            p1_req = cr;  p1_move = cm;  p0_req = orq; p0_move = om;
        end
    endtask

    task automatic drive_idle_other(input bit hold);
        logic orq;
        orq = hold ? 1'b1 : 1'($urandom_range(0, 1));
        drive(1'b0, 3'($urandom), orq, 3'($urandom));
    endtask

    task automatic restart();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        exp_player = 1'b0;
        exp_cnt    = 0;
        chk("restart_player", 32'(player), 32'(exp_player));
        chk("restart_cnt", 32'(turn_cnt), 32'(exp_cnt));
        chk("restart_busy_done", 32'({busy, done}), 32'(2'b10));
    endtask

    // One turn, entered on the first negedge in the waiting-for-move phase
    task automatic do_turn(input bit use_req, input int delay, input logic [2:0] mv,
                           input int ack_delay, input bit go, input bit hold_other,
                           output bit finished);
        finished = 1'b0;
        chk("turn_player", 32'(player), 32'(exp_player));
        chk("turn_cnt", 32'(turn_cnt), 32'(exp_cnt));
        chk("turn_busy_done", 32'({busy, done}), 32'(2'b10));
        if (use_req) begin
            for (int i = 0; i < delay; i++) begin
                drive_idle_other(hold_other);
                @(negedge clk);
                chk("wait_quiet", 32'({move_valid, timeout}), 32'(0));
            end
            drive(1'b1, mv, hold_other ? 1'b1 : 1'($urandom_range(0, 1)), 3'($urandom));
            @(negedge clk);
            chk("strobe", 32'(move_valid), 32'(1));
            chk("move_out", 32'(move_out), 32'(mv));
            chk("strobe_no_timeout", 32'(timeout), 32'(0));
            chk("strobe_player", 32'(player), 32'(exp_player));
            drive(1'b0, 3'($urandom), 1'b0, 3'($urandom));
            game_ack  = 1'b1;
            game_over = 1'b1;
            @(negedge clk);
            game_ack  = 1'b0;
            game_over = 1'b0;
            start     = 1'b1;
            chk("ack_wait", 32'({move_valid, busy, done}), 32'(3'b010));
            for (int i = 0; i < ack_delay; i++) begin
                @(negedge clk);
                chk("ack_wait_hold", 32'({move_valid, busy, move_out}), 32'({2'b01, mv}));
            end
            start     = 1'b0;
            game_ack  = 1'b1;
            game_over = go;
            @(negedge clk);
            game_ack  = 1'b0;
            game_over = 1'b0;
            if (go) begin
                exp_cnt++;
                chk("over_busy_done", 32'({busy, done}), 32'(2'b01));
                chk("over_cnt", 32'(turn_cnt), 32'(exp_cnt));
                chk("over_player", 32'(player), 32'(exp_player));
                finished = 1'b1;
                return;
            end
            chk("switch_state", 32'({timeout, move_valid, busy, turn_cnt}), 32'({3'b001, 6'(exp_cnt)}));
        end else begin
            for (int i = 0; i < int'(TC) - 1; i++) begin
                drive_idle_other(hold_other);
                @(negedge clk);
                chk("timer_quiet", 32'({move_valid, timeout}), 32'(0));
            end
            drive_idle_other(hold_other);
            @(negedge clk);
            chk("timeout_pulse", 32'({timeout, move_valid}), 32'(2'b10));
            drive(1'b0, 3'($urandom), 1'b0, 3'($urandom));
        end
        @(negedge clk);
        exp_cnt++;
        exp_player = ~exp_player;
        chk("next_player", 32'(player), 32'(exp_player));
        chk("next_cnt", 32'(turn_cnt), 32'(exp_cnt));
        chk("next_quiet", 32'({timeout, move_valid}), 32'(0));
        if (exp_cnt == int'(MT)) begin
            chk("limit_busy_done", 32'({busy, done}), 32'(2'b01));
            finished = 1'b1;
        end else begin
            chk("next_busy_done", 32'({busy, done}), 32'(2'b10));
        end
    endtask

    initial begin
        rst = 1'b0; start = 1'b0; game_ack = 1'b0; game_over = 1'b0;
        p0_req = 1'b0; p0_move = 3'b000; p1_req = 1'b0; p1_move = 3'b000;
        exp_player = 1'b0; exp_cnt = 0;
        repeat (2) @(negedge clk);
        chk("reset_outputs", 32'({move_valid, move_out, player, timeout, turn_cnt, busy, done}), 32'(0));
        rst = 1'b1;
        @(negedge clk);
        chk("idle_hold", 32'({busy, done, move_valid}), 32'(0));

        // Directed game: move, timeout with other player requesting, late request + game over
        restart();
        do_turn(1'b1, 0, 3'b010, 2, 1'b0, 1'b0, fin);
        do_turn(1'b0, 0, 3'b000, 0, 1'b0, 1'b1, fin);
        do_turn(1'b1, int'(TC) - 1, 3'b101, 1, 1'b1, 1'b0, fin);
        chk("game_over_cnt", 32'(turn_cnt), 32'(3));
        p0_req = 1'b1; p0_move = 3'b111;
        repeat (4) begin
            @(negedge clk);
            chk("done_ignores_req", 32'({move_valid, done, busy}), 32'(3'b010));
        end
        p0_req = 1'b0;

        // Full game to the turn limit
        restart();
        for (int t = 0; t < int'(MT); t++) begin
            do_turn(1'b1, int'($urandom_range(0, 5)), 3'($urandom), int'($urandom_range(0, 3)),
                    1'b0, 1'b0, fin);
            chk("limit_fin", 32'(fin), 32'(t == int'(MT) - 1));
        end
        chk("limit_cnt", 32'(turn_cnt), 32'(MT));
        restart();

        // Random games
        for (int g = 0; g < 3; g++) begin
            fin = 1'b0;
            for (int t = 0; t < int'(MT) && !fin; t++) begin
                do_turn($urandom_range(0, 3) != 0, int'($urandom_range(0, TC - 1)), 3'($urandom),
                        int'($urandom_range(0, 4)), $urandom_range(0, 5) == 0,
                        1'($urandom_range(0, 1)), fin);
            end
            chk("random_game_done", 32'({fin, done, busy}), 32'(3'b110));
            restart();
        end

        // Asynchronous reset while waiting for the acknowledge
        drive(1'b1, 3'b011, 1'b0, 3'b000);
        @(negedge clk);
        drive(1'b0, 3'b000, 1'b0, 3'b000);
        @(negedge clk);
        chk("pre_reset_wait_ack", 32'({busy, move_valid, move_out}), 32'({2'b10, 3'b011}));
        #2 rst = 1'b0;
        #1 chk("async_reset", 32'({move_valid, move_out, player, timeout, turn_cnt, busy, done}), 32'(0));
        @(negedge clk);
        rst = 1'b1;
        game_ack = 1'b1;
        @(negedge clk);
        game_ack = 1'b0;
        chk("ack_after_reset", 32'({move_valid, move_out, player, timeout, turn_cnt, busy, done}), 32'(0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
